sdrc_bank_fsm_p: RTL and testbench

- Parametrised next-generation per-bank controller, one instance per SDRAM bank, between sdrc_req_gen and sdrc_xfr_ctl.
- Accepts a chunk request, resolves page hit/miss/closed, and issues PRE/ACT/RD/WR to xfr_ctl under tRAS/tRP/tRCD/tWR timing.
- Adds over the previous generation: generic row/col/ID/len/timer widths, write-recovery (tWR) gating, per-request close-page (auto precharge after transfer), and an optional idle-page timeout.

---
 rtl/sdrc_bank_fsm_p.sv | 215 +++++++++++++++++++++
 tb/tb_sdrc_bank_fsm_p.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sdrc_bank_fsm_p.sv
// rtl/sdrc_bank_fsm_p.sv - per-bank SDRAM controller: page hit/miss resolution, PRE/ACT/RD/WR sequencing
// Optional idle-page auto-close enabled by defining SDRC_PAGE_TIMEOUT_EN.
module sdrc_bank_fsm_p #(
  parameter int ROW_W = 13,
  parameter int COL_W = 13,
  parameter int ID_W  = 4,
  parameter int LEN_W = 7,
  parameter int TMR_W = 4,
  parameter int TO_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r2b_req,
  input  logic [ID_W-1:0]  r2b_id,
  input  logic             r2b_start,
  input  logic             r2b_last,
  input  logic             r2b_wrap,
  input  logic             r2b_write,
  input  logic             r2b_close,
  input  logic [ROW_W-1:0] r2b_raddr,
  input  logic [COL_W-1:0] r2b_caddr,
  input  logic [LEN_W-1:0] r2b_len,
  output logic             b2r_ack,
  output logic             b2x_req,
  output logic [1:0]       b2x_cmd,
  output logic [ROW_W-1:0] b2x_addr,
  output logic [ID_W-1:0]  b2x_id,
  output logic             b2x_start,
  output logic             b2x_last,
  output logic             b2x_wrap,
  output logic [LEN_W-1:0] b2x_len,
  input  logic             x2b_ack,
  input  logic             x2b_refresh,
  input  logic             x2b_pre_ok,
  input  logic             x2b_act_ok,
  input  logic             x2b_rdok,
  input  logic             x2b_wrok,
  input  logic             xfr_ok,
  input  logic [TMR_W-1:0] tras_delay,
  input  logic [TMR_W-1:0] trp_delay,
  input  logic [TMR_W-1:0] trcd_delay,
  input  logic [TMR_W-1:0] twr_delay,
  input  logic [TO_W-1:0]  page_timeout,
  output logic [ROW_W-1:0] bank_row,
  output logic             bank_open,
  output logic             tras_ok
);

  localparam logic [1:0] OP_PRE = 2'b00;
  localparam logic [1:0] OP_ACT = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ACT   = 3'd2;
  localparam logic [2:0] S_XFR   = 3'd3;
  localparam logic [2:0] S_CLOSE = 3'd4;

  logic [2:0]       state;
  logic [ID_W-1:0]  l_id;
  logic             l_start, l_last, l_wrap, l_write, l_close;
  logic [ROW_W-1:0] l_raddr;
  logic [COL_W-1:0] l_caddr;
  logic [LEN_W-1:0] l_len;
  logic [TMR_W-1:0] tras_cntr, twr_cntr, timer0;
  logic             twr_ok;
  logic             open_eff;
  logic             hit;
  logic             cmd_fire;
  logic             to_fire;
  logic [ROW_W-1:0] pre_addr;

  assign tras_ok   = (tras_cntr == '0);
  assign twr_ok    = (twr_cntr == '0);
  // A refresh arriving in IDLE closes the page this cycle, so it cannot count as a hit.
  assign open_eff  = bank_open & ~x2b_refresh;
  assign hit       = open_eff & (r2b_raddr == bank_row);
  assign b2r_ack   = (state == S_IDLE) & r2b_req;
  assign cmd_fire  = b2x_req & x2b_ack;
  assign pre_addr  = l_raddr & ~(ROW_W'(1) << 10);

  assign b2x_id    = l_id;
  assign b2x_start = l_start;
  assign b2x_last  = l_last;
  assign b2x_wrap  = l_wrap;
  assign b2x_len   = l_len;

  always_comb begin
    b2x_req  = 1'b0;
    b2x_cmd  = OP_PRE;
    b2x_addr = '0;
    case (state)
      S_PRE, S_CLOSE: begin
        b2x_req  = tras_ok & twr_ok & x2b_pre_ok;
        b2x_addr = pre_addr;
      end
      S_ACT: begin
        b2x_req  = (timer0 == '0) & x2b_act_ok;
        b2x_cmd  = OP_ACT;
        b2x_addr = l_raddr;
      end
      S_XFR: begin
        b2x_req  = (timer0 == '0) & xfr_ok & (l_write ? x2b_wrok : x2b_rdok);
        b2x_cmd  = l_write ? OP_WR : OP_RD;
        b2x_addr = ROW_W'(l_caddr);
      end
      default: ;
    endcase
  end

`ifdef SDRC_PAGE_TIMEOUT_EN
  logic [TO_W-1:0] idle_cntr;

  assign to_fire = (state == S_IDLE) & open_eff & ~r2b_req &
                   (page_timeout != '0) & (idle_cntr == page_timeout);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cntr <= '0;
    end else if ((state == S_IDLE) & bank_open & ~r2b_req & ~to_fire) begin
      if (idle_cntr != '1) idle_cntr <= idle_cntr + TO_W'(1);
    end else begin
      idle_cntr <= '0;
    end
  end
`else
  logic unused_page_timeout;
  assign unused_page_timeout = ^page_timeout;
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      l_id      <= '0;
      l_start   <= 1'b0;
      l_last    <= 1'b0;
      l_wrap    <= 1'b0;
      l_write   <= 1'b0;
      l_close   <= 1'b0;
      l_raddr   <= '0;
      l_caddr   <= '0;
      l_len     <= '0;
      tras_cntr <= '0;
      twr_cntr  <= '0;
      timer0    <= '0;
      bank_open <= 1'b0;
      bank_row  <= '0;
    end else begin
      if (tras_cntr != '0) tras_cntr <= tras_cntr - TMR_W'(1);
      if (twr_cntr != '0)  twr_cntr  <= twr_cntr - TMR_W'(1);
      if (timer0 != '0)    timer0    <= timer0 - TMR_W'(1);

      if (b2r_ack) begin
        l_id    <= r2b_id;
        l_start <= r2b_start;
        l_last  <= r2b_last;
        l_wrap  <= r2b_wrap;
        l_write <= r2b_write;
        l_close <= r2b_close;
        l_raddr <= r2b_raddr;
        l_caddr <= r2b_caddr;
        l_len   <= r2b_len;
      end

      case (state)
        S_IDLE: begin
          if (r2b_req)      state <= hit ? S_XFR : (open_eff ? S_PRE : S_ACT);
          else if (to_fire) state <= S_CLOSE;
        end
        S_PRE: begin
          if (x2b_refresh) begin
            state <= S_ACT;
          end else if (cmd_fire) begin
            bank_open <= 1'b0;
            timer0    <= trp_delay;
            state     <= S_ACT;
          end
        end
        S_ACT: begin
          if (cmd_fire) begin
            bank_open <= 1'b1;
            bank_row  <= l_raddr;
            tras_cntr <= tras_delay;
            timer0    <= trcd_delay;
            state     <= S_XFR;
          end
        end
        S_XFR: begin
          if (x2b_refresh) begin
            state <= S_ACT;
          end else if (cmd_fire) begin
            if (l_write) twr_cntr <= twr_delay;
            state <= l_close ? S_CLOSE : S_IDLE;
          end
        end
        S_CLOSE: begin
          if (x2b_refresh) begin
            state <= S_IDLE;
          end else if (cmd_fire) begin
            bank_open <= 1'b0;
            timer0    <= trp_delay;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Refresh closes every row and overrides an activate in the same cycle.
      if (x2b_refresh) bank_open <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdrc_bank_fsm_p.sv
// tb/tb_sdrc_bank_fsm_p.sv - directed self-checking bench for sdrc_bank_fsm_p
module tb_sdrc_bank_fsm_p;

  localparam logic [1:0] OP_PRE = 2'b00;
  localparam logic [1:0] OP_ACT = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_close;
  logic [3:0]  r2b_id;
  logic [12:0] r2b_raddr, r2b_caddr;
  logic [6:0]  r2b_len;
  logic        b2r_ack, b2x_req, b2x_start, b2x_last, b2x_wrap;
  logic [1:0]  b2x_cmd;
  logic [12:0] b2x_addr, bank_row;
  logic [3:0]  b2x_id;
  logic [6:0]  b2x_len;
  logic        x2b_ack, x2b_refresh, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok;
  logic [3:0]  tras_delay, trp_delay, trcd_delay, twr_delay;
  logic [7:0]  page_timeout;
  logic        bank_open, tras_ok;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdrc_bank_fsm_p dut (
    .clk(clk), .reset_n(reset_n),
    .r2b_req(r2b_req), .r2b_id(r2b_id), .r2b_start(r2b_start), .r2b_last(r2b_last),
    .r2b_wrap(r2b_wrap), .r2b_write(r2b_write), .r2b_close(r2b_close),
    .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len),
    .b2r_ack(b2r_ack), .b2x_req(b2x_req), .b2x_cmd(b2x_cmd), .b2x_addr(b2x_addr),
    .b2x_id(b2x_id), .b2x_start(b2x_start), .b2x_last(b2x_last), .b2x_wrap(b2x_wrap),
    .b2x_len(b2x_len), .x2b_ack(x2b_ack), .x2b_refresh(x2b_refresh),
    .x2b_pre_ok(x2b_pre_ok), .x2b_act_ok(x2b_act_ok), .x2b_rdok(x2b_rdok),
    .x2b_wrok(x2b_wrok), .xfr_ok(xfr_ok),
    .tras_delay(tras_delay), .trp_delay(trp_delay), .trcd_delay(trcd_delay),
    .twr_delay(twr_delay), .page_timeout(page_timeout),
    .bank_row(bank_row), .bank_open(bank_open), .tras_ok(tras_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [12:0] row, input logic [12:0] col, input logic [3:0] id,
                     input logic [6:0] len, input logic wr, input logic cl, input string tag);
    r2b_raddr = row; r2b_caddr = col; r2b_id = id; r2b_len = len;
    r2b_write = wr; r2b_close = cl; r2b_req = 1'b1;
    #1;
    chk({tag, "_ack"}, b2r_ack, 1);
    step();
    r2b_req = 1'b0;
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [12:0] addr, input int exp_wait,
                       input string tag);
    int n = 0;
    while (!b2x_req && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, n, exp_wait);
    chk({tag, "_cmd"}, b2x_cmd, cmd);
    chk({tag, "_addr"}, b2x_addr, addr);
    x2b_ack = 1'b1;
    step();
    x2b_ack = 1'b0;
  endtask

  initial begin
    int seen;
    reset_n = 1'b0;
    r2b_req = 0; r2b_start = 1; r2b_last = 1; r2b_wrap = 0; r2b_write = 0; r2b_close = 0;
    r2b_id = 0; r2b_raddr = 0; r2b_caddr = 0; r2b_len = 0;
    x2b_ack = 0; x2b_refresh = 0;
    x2b_pre_ok = 1; x2b_act_ok = 1; x2b_rdok = 1; x2b_wrok = 1; xfr_ok = 1;
    tras_delay = 4'd5; trp_delay = 4'd3; trcd_delay = 4'd2; twr_delay = 4'd4;
    page_timeout = 8'd8;
    step(); step();
    chk("rst_ack", b2r_ack, 0);
    chk("rst_req", b2x_req, 0);
    chk("rst_open", bank_open, 0);
    chk("rst_row", bank_row, 0);
    chk("rst_tras_ok", tras_ok, 1);
    chk("rst_cmd", b2x_cmd, OP_PRE);
    chk("rst_addr", b2x_addr, 0);
    reset_n = 1'b1;
    step();

    // closed bank read
    req(13'h123, 13'h010, 4'd5, 7'd8, 1'b0, 1'b0, "t1_req");
    issue(OP_ACT, 13'h123, 0, "t1_act");
    chk("t1_open", bank_open, 1);
    chk("t1_row", bank_row, 13'h123);
    chk("t1_id", b2x_id, 5);
    chk("t1_len", b2x_len, 8);
    chk("t1_start", b2x_start, 1);
    chk("t1_wrap", b2x_wrap, 0);
    issue(OP_RD, 13'h010, 2, "t1_rd");
    chk("t1_tras_ok", tras_ok, 0);

    // hit write, then miss gated by tRAS/tWR; bit 10 forced low on PRE
    req(13'h123, 13'h020, 4'd6, 7'd1, 1'b1, 1'b0, "t2_hit");
    issue(OP_WR, 13'h020, 0, "t2_wr");
    req(13'h456, 13'h030, 4'd7, 7'd2, 1'b1, 1'b0, "t2_miss");
    issue(OP_PRE, 13'h056, 3, "t2_pre");
    chk("t2_closed", bank_open, 0);
    issue(OP_ACT, 13'h456, 3, "t2_act");
    issue(OP_WR, 13'h030, 2, "t2_wr2");

    // close-page write
    req(13'h456, 13'h030, 4'd7, 7'd2, 1'b1, 1'b1, "t3_req");
    issue(OP_WR, 13'h030, 0, "t3_wr");
    issue(OP_PRE, 13'h056, 4, "t3_close");
    chk("t3_open", bank_open, 0);
    chk("t3_idle_req", b2x_req, 0);
    req(13'h456, 13'h040, 4'd8, 7'd4, 1'b0, 1'b0, "t3_reopen");
    issue(OP_ACT, 13'h456, 2, "t3_act");

    // refresh during XFR wait
    x2b_refresh = 1'b1;
    step();
    x2b_refresh = 1'b0;
    chk("t4_open", bank_open, 0);
    chk("t4_req", b2x_req, 0);
    chk("t4_cmd", b2x_cmd, OP_ACT);
    issue(OP_ACT, 13'h456, 1, "t4_act");
    chk("t4_open2", bank_open, 1);
    chk("t4_id", b2x_id, 8);
    chk("t4_len", b2x_len, 4);
    issue(OP_RD, 13'h040, 2, "t4_rd");

`ifdef SDRC_PAGE_TIMEOUT_EN
    issue(OP_PRE, 13'h056, 9, "t5_to_pre");
    chk("t5_closed", bank_open, 0);
    req(13'h456, 13'h050, 4'd9, 7'd2, 1'b0, 1'b0, "t5_req");
    issue(OP_ACT, 13'h456, 2, "t5_act");
    issue(OP_RD, 13'h050, 2, "t5_rd");
    for (int i = 0; i < 8; i++) step();
    req(13'h456, 13'h060, 4'd10, 7'd2, 1'b0, 1'b0, "t5_race");
    issue(OP_RD, 13'h060, 0, "t5_race_rd");
    page_timeout = 8'd0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (b2x_req) seen = 1;
    end
    chk("t5_to0_noreq", seen, 0);
    chk("t5_to0_open", bank_open, 1);
`else
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (b2x_req) seen = 1;
    end
    chk("t5_off_noreq", seen, 0);
    chk("t5_off_open", bank_open, 1);
`endif

    // reset mid-ACT wait
    req(13'h200, 13'h001, 4'd3, 7'd1, 1'b0, 1'b0, "t6_req");
    issue(OP_PRE, 13'h200, 0, "t6_pre");
    step();
    chk("t6_actwait", b2x_req, 0);
    reset_n = 1'b0;
    step();
    chk("t6_req", b2x_req, 0);
    chk("t6_open", bank_open, 0);
    chk("t6_row", bank_row, 0);
    chk("t6_tras_ok", tras_ok, 1);
    chk("t6_cmd", b2x_cmd, OP_PRE);
    chk("t6_addr", b2x_addr, 0);
    chk("t6_id", b2x_id, 0);
    reset_n = 1'b1;
    r2b_req = 1'b1;
    #1;
    chk("t6_idle_ack", b2r_ack, 1);
    r2b_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
